nlm_line_buffer: RTL and testbench
==================================

# nlm_line_buffer

Parametrised multi-row line buffer for the NLM denoise datapath. It takes a raster pixel stream, one pixel per cycle at most, and stores the previous ROWS-1 lines in internal simple dual-port SRAM banks. For every input pixel it emits a vertically aligned column of ROWS pixels: the current pixel plus the pixels directly above it. The column feeds the NLM window/patch generator and replaces the hand-instantiated per-line SRAMs used so far.

## Interface
- DATA_WIDTH, 16: pixel width in bits.
- ADDR_WIDTH, 12: bank address width; the maximum line width is MEM_DEPTH = 2**ADDR_WIDTH.
- ROWS, 5: number of output rows. Range 2..16. The block holds ROWS-1 banks.
- clk  in  1: single clock; all logic on its rising edge.
- rst  in  1: synchronous, active-high reset.
- img_width_i  in  ADDR_WIDTH+1: line width in pixels. Latched on SOF. Valid range 1..MEM_DEPTH. 0 or >MEM_DEPTH is clamped to MEM_DEPTH.
- pix_i  in  DATA_WIDTH: input pixel.
- pix_vld_i  in  1: pix_i is valid this cycle.
- sof_i  in  1: first pixel of a frame. Sampled only when pix_vld_i=1.
- col_o  out  ROWS*DATA_WIDTH: output column. Lane k, bits [k*DATA_WIDTH +: DATA_WIDTH], is the pixel k lines above the current pixel. Lane 0 is the current pixel.
- col_vld_o  out  1: col_o is valid.
- rows_vld_o  out  ROWS: per-lane valid. Bit k=1 when line current-k exists in this frame.
- eol_o  out  1: col_o belongs to the last column of a line.

## Operation
- **State**
  - col_cnt: ADDR_WIDTH+1 bits.
  - wr_ptr: bank index 0..ROWS-2, points at the bank holding the oldest line.
  - fill: 0..ROWS-1, counts completed lines in the frame; saturates at ROWS-1.
  - width_q: latched line width.
- **Accepted pixel (pix_vld_i=1)**
  - Every bank is read at address col_cnt.
  - pix_i is written into bank wr_ptr at address col_cnt in the same cycle.
  - Read-during-write to the same address returns the OLD data. This is required: lane ROWS-1 reads the line being overwritten.
- **Lane mapping:** lane k (k=1..ROWS-1) takes bank (wr_ptr + ROWS-1-k) mod (ROWS-1).
- **Masking**
  - rows_vld_o[0]=1 and rows_vld_o[k]=(fill>=k), using fill as it was on the input cycle.
  - Lanes with rows_vld_o[k]=0 output 0 on col_o. Bank contents are never reset; the mask hides stale data.
- **End of line:** when col_cnt = width_q-1 on an accepted pixel:
  - col_cnt returns to 0.
  - wr_ptr advances by 1 mod (ROWS-1).
  - fill increments, saturating at ROWS-1.
  - eol_o is asserted for that column.
- **SOF:** sof_i=1 with pix_vld_i=1 means that pixel is column 0 of line 0.
  - The block first treats col_cnt, wr_ptr and fill as 0 and latches width_q from img_width_i.
  - It then processes the pixel normally, so after the edge col_cnt=1, or 0 if width=1.
  - This applies mid-line too: the partial line is abandoned.
- **Idle cycle (pix_vld_i=0):** no state change, no memory write.
- **ROWS=2:** one bank, wr_ptr stays 0.

## Timing
- Latency is exactly 1 cycle. col_o, col_vld_o, rows_vld_o and eol_o are registered together and appear the cycle after the accepted pixel.
- Throughput is 1 pixel/cycle. Arbitrary gaps are allowed.
- When col_vld_o=0, col_o, rows_vld_o and eol_o hold their last values. Only col_vld_o is guaranteed to be 0.
- Reset values:
  - Outputs: col_o=0, col_vld_o=0, rows_vld_o=0, eol_o=0.
  - Internal: col_cnt=0, wr_ptr=0, fill=0, width_q=MEM_DEPTH.
- Reset mid-line: any pixel accepted in the reset cycle is dropped, and outputs are 0 in the following cycle.
- rst has priority over sof_i and pix_vld_i.
- Pixels arriving before any SOF after reset are processed with width_q=MEM_DEPTH.

## Test plan
- **Basic fill.** ROWS=3, width 4, frame of 4 lines, pix = line*16+col, continuous valid, sof on the first pixel.
  - Line 0 columns: rows_vld=001, col_o lanes 1 and 2 = 0.
  - Line 2, col 1: lanes (0,1,2) = (0x21, 0x11, 0x01), rows_vld=111.
  - eol_o on every col 3.
- **Wrap and pointer rotation.** Same setup, line 3, col 2: lanes = (0x32, 0x22, 0x12). This confirms that read-old-data on the overwritten bank returns line 1.
- **Gaps.** Insert random pix_vld_i=0 cycles.
  - The output sequence matches the gap-free run, with each column 1 cycle after its pixel.
  - No col_vld_o during gaps.
- **Mid-line SOF.** Raise sof at line 2, col 2, with new width 2.
  - That column outputs rows_vld=001 and lanes 1 and 2 = 0.
  - eol_o on the next pixel.
  - After one more line, rows_vld=011.
- **Width limits.** width=1: every pixel has eol_o=1, and fill reaches 2 after 2 pixels. img_width_i=0: width behaves as MEM_DEPTH (eol only at col MEM_DEPTH-1).
- **Reset mid-frame.** Assert rst for 1 cycle at line 1, col 2.
  - Next cycle all outputs are 0.
  - The following pixels without sof are treated as line 0, col 0, with rows_vld=001.

Source files
------------

// File: rtl/nlm_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : nlm_line_buffer
//  Purpose  : Multi-row line buffer for the NLM denoise datapath. Stores the
//             previous ROWS-1 lines of a raster stream in simple dual-port
//             banks and emits, one cycle after each accepted pixel, the
//             vertically aligned column (current pixel plus ROWS-1 above).
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             img_width_i       - line width, latched on SOF (0/oversize ->
//                                 MEM_DEPTH)
//             pix_i, pix_vld_i  - input pixel and its valid
//             sof_i             - first pixel of frame (qualified by valid)
//             col_o             - ROWS lanes, lane k = pixel k lines above
//             col_vld_o         - column valid
//             rows_vld_o        - per-lane valid (line current-k exists)
//             eol_o             - column is the last of its line
//  Revision : 1.0  initial release
// ============================================================================
module nlm_line_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int ROWS       = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_WIDTH:0]        img_width_i,
  input  logic [DATA_WIDTH-1:0]      pix_i,
  input  logic                       pix_vld_i,
  input  logic                       sof_i,
  output logic [ROWS*DATA_WIDTH-1:0] col_o,
  output logic                       col_vld_o,
  output logic [ROWS-1:0]            rows_vld_o,
  output logic                       eol_o
);

  localparam int NBANK     = ROWS - 1;
  localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;
  localparam int PTR_W     = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int FILL_W    = $clog2(ROWS);

  localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_W    = (ADDR_WIDTH+1)'(1);
  localparam logic [PTR_W-1:0]    LAST_PTR = PTR_W'(NBANK - 1);
  localparam logic [FILL_W-1:0]   FILL_MAX = FILL_W'(ROWS - 1);

  // Frame position state
  logic [ADDR_WIDTH:0]   col_cnt_q, col_cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q,  wr_ptr_d;
  logic [FILL_W-1:0]     fill_q,    fill_d;
  logic [ADDR_WIDTH:0]   width_q,   width_d;

  // Output registers
  logic                  col_vld_q;
  logic [DATA_WIDTH-1:0] lane0_q;
  logic [ROWS-1:0]       rows_vld_q, rows_vld_d;
  logic                  eol_q;
  logic [PTR_W-1:0]      lane_ptr_q;

  // State as seen by the current pixel (SOF substitutes a fresh frame)
  logic                  acc;
  logic                  new_frame;
  logic [ADDR_WIDTH:0]   width_clamp;
  logic [ADDR_WIDTH:0]   cnt_cur;
  logic [PTR_W-1:0]      ptr_cur;
  logic [FILL_W-1:0]     fill_cur;
  logic [ADDR_WIDTH:0]   width_cur;
  logic                  at_eol;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic [NBANK*DATA_WIDTH-1:0] bank_rd;

  always_comb begin
    acc         = pix_vld_i & ~rst;
    new_frame   = acc & sof_i;
    width_clamp = ((img_width_i == '0) || (img_width_i > DEPTH_W)) ? DEPTH_W : img_width_i;

    cnt_cur   = new_frame ? '0          : col_cnt_q;
    ptr_cur   = new_frame ? '0          : wr_ptr_q;
    fill_cur  = new_frame ? '0          : fill_q;
    width_cur = new_frame ? width_clamp : width_q;

    at_eol  = (cnt_cur == (width_cur - ONE_W));
    rd_addr = cnt_cur[ADDR_WIDTH-1:0];

    col_cnt_d  = col_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    width_d    = width_q;
    rows_vld_d = rows_vld_q;

    if (acc) begin
      width_d = width_cur;
      if (at_eol) begin
        col_cnt_d = '0;
        wr_ptr_d  = (ptr_cur == LAST_PTR) ? '0 : ptr_cur + PTR_W'(1);
        fill_d    = (fill_cur == FILL_MAX) ? fill_cur : fill_cur + FILL_W'(1);
      end else begin
        col_cnt_d = cnt_cur + ONE_W;
        wr_ptr_d  = ptr_cur;
        fill_d    = fill_cur;
      end
      for (int k = 0; k < ROWS; k++) begin
        rows_vld_d[k] = (fill_cur >= FILL_W'(k));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      width_q    <= DEPTH_W;
      col_vld_q  <= 1'b0;
      lane0_q    <= '0;
      rows_vld_q <= '0;
      eol_q      <= 1'b0;
      lane_ptr_q <= '0;
    end else begin
      col_cnt_q  <= col_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      width_q    <= width_d;
      rows_vld_q <= rows_vld_d;
      col_vld_q  <= pix_vld_i;
      if (pix_vld_i) begin
        lane0_q    <= pix_i;
        eol_q      <= at_eol;
        lane_ptr_q <= ptr_cur;
      end
    end
  end

  // One bank per stored line. The read register samples the array before the
  // write lands, so the bank being overwritten still yields the oldest line.
  // Bank contents are never cleared; stale data is hidden by rows_vld.
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (acc) begin
        if (ptr_cur == PTR_W'(b)) begin
          mem_q[rd_addr] <= pix_i;
        end
        rd_q <= mem_q[rd_addr];
      end
    end

    assign bank_rd[b*DATA_WIDTH +: DATA_WIDTH] = rd_q;
  end

  // Lane k shows bank (ptr + NBANK - k) mod NBANK, where ptr is the oldest
  // bank at the time the pixel was accepted.
  always_comb begin
    col_o                 = '0;
    col_o[DATA_WIDTH-1:0] = lane0_q;
    for (int k = 1; k < ROWS; k++) begin
      int sel;
      sel = int'(lane_ptr_q) + NBANK - k;
      if (sel >= NBANK) begin
        sel = sel - NBANK;
      end
      if (rows_vld_q[k]) begin
        col_o[k*DATA_WIDTH +: DATA_WIDTH] = bank_rd[sel*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign col_vld_o  = col_vld_q;
  assign rows_vld_o = rows_vld_q;
  assign eol_o      = eol_q;

endmodule
`default_nettype wire

// File: tb/tb_nlm_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nlm_line_buffer
//  Purpose  : Self-checking bench for nlm_line_buffer (ROWS=3, 32-pixel
//             banks). A frame-history model predicts every output cycle;
//             literal expectations pin the model at known points.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nlm_line_buffer;

  localparam int DW   = 16;
  localparam int AW   = 5;
  localparam int ROWS = 3;
  localparam int MD   = 1 << AW;

  logic               clk = 1'b0;
  logic               rst;
  logic [AW:0]        img_width_i;
  logic [DW-1:0]      pix_i;
  logic               pix_vld_i;
  logic               sof_i;
  logic [ROWS*DW-1:0] col_o;
  logic               col_vld_o;
  logic [ROWS-1:0]    rows_vld_o;
  logic               eol_o;

  always #5 clk = ~clk;

  nlm_line_buffer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .ROWS       (ROWS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .img_width_i (img_width_i),
    .pix_i       (pix_i),
    .pix_vld_i   (pix_vld_i),
    .sof_i       (sof_i),
    .col_o       (col_o),
    .col_vld_o   (col_vld_o),
    .rows_vld_o  (rows_vld_o),
    .eol_o       (eol_o)
  );

  typedef struct packed {
    logic               vld;
    logic [ROWS*DW-1:0] col;
    logic [ROWS-1:0]    rows;
    logic               eol;
  } exp_t;

  exp_t exp_cur = '0;
  exp_t exp_next;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  // Model: position in frame plus full pixel history of recent lines
  int            m_line = 0;
  int            m_col  = 0;
  int            m_width = MD;
  logic [DW-1:0] hist [16][MD];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  function automatic int clampw(input int w);
    return ((w == 0) || (w > MD)) ? MD : w;
  endfunction

  // Drive one cycle, advance the model, and land just after the clock edge.
  task automatic step(input bit r, input bit v, input bit s, input logic [DW-1:0] p, input int w);
    rst         = r;
    pix_vld_i   = v;
    sof_i       = s;
    pix_i       = p;
    img_width_i = w[AW:0];
    exp_next     = exp_cur;
    exp_next.vld = 1'b0;
    if (r) begin
      exp_next = '0;
      m_line   = 0;
      m_col    = 0;
      m_width  = MD;
    end else if (v) begin
      if (s) begin
        m_line  = 0;
        m_col   = 0;
        m_width = clampw(w);
      end
      exp_next.vld          = 1'b1;
      exp_next.col          = '0;
      exp_next.col[DW-1:0]  = p;
      for (int k = 0; k < ROWS; k++) begin
        exp_next.rows[k] = (m_line >= k);
        if (k > 0 && m_line >= k) begin
          exp_next.col[k*DW +: DW] = hist[(m_line - k) % 16][m_col];
        end
      end
      exp_next.eol = (m_col == m_width - 1);
      hist[m_line % 16][m_col] = p;
      if (exp_next.eol) begin
        m_col = 0;
        m_line++;
      end else begin
        m_col++;
      end
    end
    @(posedge clk);
    #1;
    exp_cur = exp_next;
  endtask

  // Literal expectation checked against both the DUT and the model
  task automatic pin(input string name, input bit v, input logic [DW-1:0] l0,
                     input logic [DW-1:0] l1, input logic [DW-1:0] l2,
                     input logic [ROWS-1:0] rv, input bit e);
    logic [ROWS*DW-1:0] c;
    c = {l2, l1, l0};
    chk({name, ".vld"},  64'(col_vld_o),  64'(v));
    chk({name, ".col"},  64'(col_o),      64'(c));
    chk({name, ".rows"}, 64'(rows_vld_o), 64'(rv));
    chk({name, ".eol"},  64'(eol_o),      64'(e));
    chk({name, ".model"}, 64'(exp_cur.col), 64'(c));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc.col_vld", 64'(col_vld_o),  64'(exp_cur.vld));
      chk("cyc.col",     64'(col_o),      64'(exp_cur.col));
      chk("cyc.rows",    64'(rows_vld_o), 64'(exp_cur.rows));
      chk("cyc.eol",     64'(eol_o),      64'(exp_cur.eol));
    end
  end

  initial begin
    rst = 1'b1; pix_vld_i = 1'b0; sof_i = 1'b0; pix_i = '0; img_width_i = '0;

    step(1, 1, 1, 16'h1234, 4);
    step(1, 0, 0, 16'h0, 0);
    chk_en = 1'b1;
    pin("reset", 0, 16'h0, 16'h0, 16'h0, 3'b000, 0);

    // Basic fill and pointer wrap, width 4, four lines
    for (int ln = 0; ln < 4; ln++) begin
      for (int c = 0; c < 4; c++) begin
        step(0, 1, (ln == 0 && c == 0), 16'(ln * 16 + c), 4);
        if (ln == 0) pin("fill.line0", 1, 16'(c), 16'h0, 16'h0, 3'b001, (c == 3));
        if (ln == 1 && c == 0) pin("fill.l1c0", 1, 16'h10, 16'h00, 16'h0, 3'b011, 0);
        if (ln == 2 && c == 1) pin("fill.l2c1", 1, 16'h21, 16'h11, 16'h01, 3'b111, 0);
        if (ln == 3 && c == 2) pin("wrap.l3c2", 1, 16'h32, 16'h22, 16'h12, 3'b111, 0);
        if (c == 3) chk("fill.eol", 64'(eol_o), 64'(1));
      end
    end
    step(0, 0, 0, 16'h0, 4);
    step(0, 0, 1, 16'hFFFF, 7);

    // Same frame with random gaps (sof/pixel noise on idle cycles is ignored)
    for (int ln = 0; ln < 4; ln++) begin
      for (int c = 0; c < 4; c++) begin
        while ($urandom_range(0, 2) == 0) step(0, 0, 1'($urandom), 16'($urandom), 4);
        step(0, 1, (ln == 0 && c == 0), 16'(ln * 16 + c), 4);
        if (ln == 2 && c == 1) pin("gap.l2c1", 1, 16'h21, 16'h11, 16'h01, 3'b111, 0);
        if (ln == 3 && c == 2) pin("gap.l3c2", 1, 16'h32, 16'h22, 16'h12, 3'b111, 0);
      end
    end

    // Mid-line SOF at line 2 col 2, new width 2
    for (int i = 0; i < 10; i++) step(0, 1, (i == 0), 16'(i), 4);
    step(0, 1, 1, 16'hA0, 2);
    pin("sof.first", 1, 16'hA0, 16'h0, 16'h0, 3'b001, 0);
    step(0, 1, 0, 16'hA1, 4);
    pin("sof.eol", 1, 16'hA1, 16'h0, 16'h0, 3'b001, 1);
    step(0, 1, 0, 16'hB0, 4);
    pin("sof.line1", 1, 16'hB0, 16'hA0, 16'h0, 3'b011, 0);
    step(0, 1, 0, 16'hB1, 4);
    step(0, 1, 0, 16'hC0, 4);
    pin("sof.line2", 1, 16'hC0, 16'hB0, 16'hA0, 3'b111, 0);

    // Width 1: every pixel ends a line
    step(0, 1, 1, 16'hD0, 1);
    pin("w1.p0", 1, 16'hD0, 16'h0, 16'h0, 3'b001, 1);
    step(0, 1, 0, 16'hD1, 1);
    pin("w1.p1", 1, 16'hD1, 16'hD0, 16'h0, 3'b011, 1);
    step(0, 1, 0, 16'hD2, 1);
    pin("w1.p2", 1, 16'hD2, 16'hD1, 16'hD0, 3'b111, 1);

    // Width 0 and oversize both clamp to MD
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i <= MD; i++) begin
        step(0, 1, (i == 0), 16'(i), (rep == 0) ? 0 : 50);
        if (i == MD - 2) pin("wmax.c30", 1, 16'(i), 16'h0, 16'h0, 3'b001, 0);
        if (i == MD - 1) pin("wmax.c31", 1, 16'(i), 16'h0, 16'h0, 3'b001, 1);
        if (i == MD)     pin("wmax.next", 1, 16'(i), 16'h0, 16'h0, 3'b011, 0);
      end
    end

    // Reset mid-frame at line 1 col 2
    for (int i = 0; i < 6; i++) step(0, 1, (i == 0), 16'(16'h60 + i), 4);
    step(1, 1, 0, 16'h99, 4);
    pin("rst.mid", 0, 16'h0, 16'h0, 16'h0, 3'b000, 0);
    step(0, 1, 0, 16'h50, 4);
    pin("rst.after", 1, 16'h50, 16'h0, 16'h0, 3'b001, 0);
    for (int i = 1; i < 4; i++) step(0, 1, 0, 16'(16'h50 + i), 4);
    pin("rst.nowrap", 1, 16'h53, 16'h0, 16'h0, 3'b001, 0);

    // Randomised frames, widths, gaps, sof and occasional reset
    step(0, 1, 1, 16'($urandom), 3);
    for (int i = 0; i < 2000; i++) begin
      int w;
      w = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 40) : $urandom_range(1, 6);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 79) == 0), 16'($urandom), w);
    end
    step(0, 0, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
